// File: rtl/seg7_pkg.sv
// Seven-segment encoding constants shared by the scan driver and its hex decoder.
// Segment bit order is {g,f,e,d,c,b,a}, active-high; polarity is applied at the driver outputs.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry k is the glyph for hex nibble k (0..9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_lut.sv
// Purpose: combinational hex nibble to seven-segment glyph decode.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the output follows the input.
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_CODES[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed hex display scanner with tear-free frame-boundary value updates.
// Latency: outputs lag the scan index by one cycle; loads take effect at the next frame boundary.
// Backpressure: none; iLoad is always accepted (last load in a frame wins). Macro SEG7_SCAN_DRIVER_LZB_EN adds leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iValue,
    input  logic                    iLoad,
    input  logic [NUM_DIGITS-1:0]   iBlank,
    output logic [6:0]              oSEG,
    output logic [NUM_DIGITS-1:0]   oDIG,
    output logic                    oFrame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_POL =
        (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    flag_q, flag_d;
    logic                    frame_q, frame_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;

    logic                    tick;
    logic [4*NUM_DIGITS-1:0] cur_val;
    logic [3:0]              nibble;
    logic [6:0]              seg_raw;
    logic                    lzb_blank;
    logic [NUM_DIGITS-1:0]   dig_act;

    assign tick    = (cnt_q == LAST_CNT);
    assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
    assign idx_d   = !tick ? idx_q : ((idx_q == LAST_IDX) ? '0 : idx_q + 1'b1);
    assign frame_d = tick && (idx_q == LAST_IDX);

    // The oFrame cycle is the boundary: the new value is bypassed straight into
    // the digit-0 decode so the whole frame shows one consistent value.
    always_comb begin
        cur_val = disp_q;
        if (frame_q) begin
            if (iLoad) begin
                cur_val = iValue;
            end else if (flag_q) begin
                cur_val = pend_q;
            end
        end
    end

    assign disp_d = cur_val;

    always_comb begin
        pend_d = pend_q;
        flag_d = flag_q;
        if (iLoad) begin
            pend_d = iValue;
            flag_d = !frame_q;
        end else if (frame_q) begin
            flag_d = 1'b0;
        end
    end

    assign nibble = cur_val[{idx_q, 2'b00} +: 4];

    seg7_hex_lut u_hex_lut (
        .nibble_i (nibble),
        .seg_o    (seg_raw)
    );

`ifdef SEG7_SCAN_DRIVER_LZB_EN
    // Blank a digit when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lzb_blank = 1'b0;
        if (idx_q != '0) begin
            lzb_blank = ((cur_val >> {idx_q, 2'b00}) == '0);
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    // The tick cycle drives every digit off to suppress ghosting between slots.
    assign dig_act = tick ? '0 : (NUM_DIGITS'(1) << idx_q);
    assign dig_d   = dig_act ^ DIG_POL;
    assign seg_d   = ((iBlank[idx_q] || lzb_blank) ? SEG_BLANK : seg_raw) ^ SEG_POL;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            flag_q  <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= SEG_BLANK ^ SEG_POL;
            dig_q   <= DIG_POL;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            flag_q  <= flag_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign oSEG   = seg_q;
    assign oDIG   = dig_q;
    assign oFrame = frame_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, iCLK cycles each digit is lit (legal >= 2).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0; 1 inverts oSEG and oDIG.
REQ-004 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-005 iCLK  input  1  system clock; all state changes on its rising edge.
REQ-006 iRST_N  input  1  synchronous active-low reset.
REQ-007 iValue  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 rightmost.
REQ-008 iLoad  input  1  one-cycle strobe capturing iValue.
REQ-009 iBlank  input  NUM_DIGITS  per-digit forced blank, sampled live.
REQ-010 oSEG  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-011 oDIG  output  NUM_DIGITS  one-hot digit enable, registered.
REQ-012 oFrame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Encoding (active-high) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; blank = 00.
REQ-014 A divide counter SHALL count 0..SCAN_DIV-1 and wrap; wrap cycle is the scan tick.
REQ-015 On each tick, digit index SHALL advance k -> k+1, NUM_DIGITS-1 -> 0 (frame boundary).
REQ-016 oFrame SHALL pulse high for exactly the cycle the index wraps to 0.
REQ-017 iLoad SHALL capture iValue into a pending register and set a pending flag.
REQ-018 At a frame boundary with flag set, the display register SHALL take pending and clear the flag; no mid-frame change (tear-free).
REQ-019 iLoad coincident with a frame boundary SHALL load iValue directly into the display register and leave the flag clear.
REQ-020 Multiple iLoads within one frame: last wins.
REQ-021 oDIG SHALL be one-hot at the current index; oSEG SHALL be the decoded nibble, or blank if iBlank[index] is set.
REQ-022 Outputs SHALL lag the index by exactly one cycle (registered decode).
REQ-023 The final cycle of each digit slot (tick cycle) SHALL drive oDIG all-off to suppress ghosting.
REQ-024 NUM_DIGITS=1 SHALL hold oDIG[0] on except the tick cycle; oFrame pulses every tick.

Reset
REQ-025 While iRST_N=0 at an edge: divide counter 0, index 0, display and pending 0, flag 0, oFrame 0, oSEG blank, oDIG all-off (polarity per ACTIVE_LOW).
REQ-026 Reset mid-frame SHALL discard pending data; first digit-0 enable appears one cycle after iRST_N returns high.

Configuration
REQ-027 Macro SEG7_SCAN_DRIVER_LZB_EN SHALL enable leading-zero blanking.
REQ-028 Defined: zero digits above the most-significant nonzero digit SHALL be blanked; digit 0 always shown; combined OR with iBlank.
REQ-029 Undefined: all digits shown unless iBlank set; no LZB logic synthesised.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16-entry encoding constants and SEG_BLANK.
REQ-031 Sub-module seg7_hex_lut SHALL be the sole combinational nibble-to-segment decode, instantiated once.

Verification (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0)
REQ-032 Reset, iLoad iValue=16'h12AF -> digit slots 0..3 show 71,77,5B,06; oDIG walks 0001,0010,0100,1000, 3 cycles each, off on tick.
REQ-033 iLoad 16'h0000 mid-frame -> old digits persist until oFrame, then all show 3F.
REQ-034 iLoad 16'h5555 on the oFrame cycle -> next frame shows 6D immediately; second iLoad 16'h7777 same frame -> only 07 appears from the following frame.
REQ-035 iBlank=4'b0100 -> digit 2 shows 00, others unchanged; with LZB_EN and value 16'h0030 -> digits 3,2 blank, 1 shows 4F, 0 shows 3F.
REQ-036 Assert iRST_N=0 during digit 2 with pending set -> oSEG 00, oDIG 0000; after release pending discarded, digit 0 lit next cycle.
REQ-037 ACTIVE_LOW=1 rerun of REQ-032 -> oSEG/oDIG bitwise inverted.
